// File: rtl/datapath.sv
// rtl/datapath.sv - accumulator datapath with IR, PC, 16-entry register file, ALU and Z/C flags
//
// Ports:
//   clk       rising-edge system clock
//   CLB       synchronous active-low clear of all state
//   LoadIR    capture instr_in into IR
//   IncPC     increment PC (lower priority than LoadPC)
//   SelPC     PC load source: 1 = R[r], 0 = imm
//   LoadPC    load PC from the source chosen by SelPC
//   LoadReg   write pre-edge Acc into R[r]
//   LoadAcc   load Acc from the source chosen by SelAcc
//   SelAcc    Acc source: 00 ALU, 01 R[r], 10 imm, 11 hold
//   SelALU    [3:2] op: 00 pass, 01 NOR, 10 ADD, 11 SUB; [1:0] shift: 01 SHL1, 11 SHR1, else none
//   instr_in  12-bit instruction word from program memory
//   PC        program counter / program memory address
//   Opcode    IR[11:8]
//   Z, C      registered zero and carry/borrow flags
//   Acc       accumulator

module datapath (
    input  logic        clk,
    input  logic        CLB,
    input  logic        LoadIR,
    input  logic        IncPC,
    input  logic        SelPC,
    input  logic        LoadPC,
    input  logic        LoadReg,
    input  logic        LoadAcc,
    input  logic [1:0]  SelAcc,
    input  logic [3:0]  SelALU,
    input  logic [11:0] instr_in,
    output logic [7:0]  PC,
    output logic [3:0]  Opcode,
    output logic        Z,
    output logic        C,
    output logic [7:0]  Acc
);

    localparam logic [1:0] ACC_ALU  = 2'b00;
    localparam logic [1:0] ACC_REG  = 2'b01;
    localparam logic [1:0] ACC_IMM  = 2'b10;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_NOR   = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;

    localparam logic [1:0] SH_LEFT  = 2'b01;
    localparam logic [1:0] SH_RIGHT = 2'b11;

    logic [11:0] ir;
    logic [7:0]  regs [16];

    logic [3:0]  r;
    logic [7:0]  imm;
    logic [7:0]  r_val;

    logic [8:0]  sum;
    logic [7:0]  op_res;
    logic        op_c;
    logic [7:0]  alu_res;
    logic        alu_c;

    // The register index and the immediate overlap in IR[3:0]; every
    // same-cycle operation sees the IR as it was before this edge.
    assign r      = ir[3:0];
    assign imm    = ir[7:0];
    assign r_val  = regs[r];
    assign Opcode = ir[11:8];

    assign sum = {1'b0, Acc} + {1'b0, r_val};

    always_comb begin
        op_res = Acc;
        op_c   = 1'b0;
        case (SelALU[3:2])
            OP_PASS: begin
                op_res = Acc;
                op_c   = 1'b0;
            end
            OP_NOR: begin
                op_res = ~(Acc | r_val);
                op_c   = 1'b0;
            end
            OP_ADD: begin
                op_res = sum[7:0];
                op_c   = sum[8];
            end
            default: begin
                op_res = Acc - r_val;
                op_c   = (Acc < r_val);
            end
        endcase
    end

    // A shift replaces the operation's carry with the bit shifted out.
    always_comb begin
        alu_res = op_res;
        alu_c   = op_c;
        case (SelALU[1:0])
            SH_LEFT: begin
                alu_res = {op_res[6:0], 1'b0};
                alu_c   = op_res[7];
            end
            SH_RIGHT: begin
                alu_res = {1'b0, op_res[7:1]};
                alu_c   = op_res[0];
            end
            default: begin
                alu_res = op_res;
                alu_c   = op_c;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!CLB) begin
            ir  <= '0;
            PC  <= '0;
            Acc <= '0;
            Z   <= 1'b0;
            C   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (LoadIR) begin
                ir <= instr_in;
            end

            // Non-blocking write of the old Acc lets a register store and
            // an Acc load share one cycle.
            if (LoadReg) begin
                regs[r] <= Acc;
            end

            if (LoadAcc) begin
                case (SelAcc)
                    ACC_ALU: begin
                        Acc <= alu_res;
                        Z   <= (alu_res == 8'h00);
                        C   <= alu_c;
                    end
                    ACC_REG: Acc <= r_val;
                    ACC_IMM: Acc <= imm;
                    default: Acc <= Acc;
                endcase
            end

            if (LoadPC) begin
                PC <= SelPC ? r_val : imm;
            end else if (IncPC) begin
                PC <= PC + 8'd1;
            end
        end
    end

endmodule
